bet_ledger: RTL and testbench
=============================

Name: bet_ledger

Overview:
- Sits downstream of the PS/2 receiver and keyboard-to-bet decoder, and upstream of the register file's bet inputs.
- Collects up to NUM_BETS colour-tagged bets and stores each in a numbered slot.
- Filters out invalid, repeated and colourless key events.
- Raises a spin request and holds the ledger locked until the spin completes, then clears the ledger for the next round.

Parameters:
- NUM_BETS, 12, number of bet slots.
- BET_W, 8, slot width: {color[1:0], opcode[5:0]}.
- CNT_W, 4, width of bet_count; must satisfy 2^CNT_W > NUM_BETS.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- key_valid  input  1  keyboard "byte received" level/strobe (read_data).
- bet_opcode  input  6  decoded bet opcode; 6'h3F = no key, 6'h3E = spin.
- color  input  3  chip colour from the Arduino; 3'b000 = no chip present.
- spin_done  input  1  single-cycle pulse from the processor side when the spin result has been consumed.
- bets_flat  output  NUM_BETS*BET_W  slot i occupies bits [i*BET_W+BET_W-1 : i*BET_W]; slot 0 holds the first bet.
- bet_count  output  CNT_W  number of filled slots.
- full  output  1  high when bet_count == NUM_BETS.
- locked  output  1  high while a spin is pending (state LOCKED).
- spin_req  output  1  one-cycle pulse on an accepted spin command.
- accept_pulse  output  1  one-cycle pulse when a bet is stored.
- reject_pulse  output  1  one-cycle pulse when a valid key event is refused.

Behaviour:
- Reset (reset == 0, asynchronous):
  - All slots = 0, bet_count = 0.
  - spin_req, accept_pulse, reject_pulse = 0; full = 0; locked = 0.
  - last_op register = 6'h3F; state = OPEN.
  - Reset asserted mid-round or while LOCKED clears everything immediately, with no spin_req.
- Event detection:
  - key_valid is registered once.
  - An event occurs in cycle N when key_valid is 1 in N and 0 in N-1. Holding key_valid high yields only one event.
- Repeat filter:
  - An event whose bet_opcode == 6'h3F produces no pulse and sets last_op = 6'h3F.
  - An event whose opcode equals last_op is dropped silently, with no pulse. This suppresses typematic repeat; the same key is accepted again only after an intervening 6'h3F or a different opcode.
  - last_op updates on every event that was not dropped by the filter.
- State OPEN, for a filtered event:
  - Opcode 6'h3E with bet_count > 0: spin_req = 1 for one cycle; go to LOCKED.
  - Opcode 6'h3E with bet_count == 0: reject_pulse; stay OPEN.
  - Any other opcode when color == 3'b000, or when full: reject_pulse; nothing stored.
  - Otherwise: slot[bet_count] = {color[1:0], bet_opcode}; bet_count increments; accept_pulse.
  - Timing: slot contents and bet_count are visible at N+1; pulses are asserted in N+1 for one cycle.
- State LOCKED:
  - locked = 1.
  - Key events are ignored entirely: no pulses and no last_op update.
  - Slots are held stable for the processor to score.
  - spin_done == 1: go to CLEAR.
- State CLEAR (one cycle):
  - All slots = 0, bet_count = 0, last_op = 6'h3F.
  - Next state is OPEN. Key events in this cycle are ignored.
- spin_done outside LOCKED is ignored.
- Simultaneous key event and spin_done in LOCKED: spin_done wins and the key event is discarded.
- Full boundary:
  - The 12th accepted bet sets full at N+1.
  - The 13th bet gets reject_pulse; bet_count saturates at NUM_BETS and never wraps.
  - Spin is still accepted while full.
- bets_flat, bet_count, full and locked are all registered outputs with no combinational input-to-output paths.

Test Plan:
1. Reset → all outputs 0; release reset, then press opcode 6'h05 with color 3'b010 → slot0 = 8'h85, bet_count = 1, accept_pulse 1 cycle at N+1.
2. Hold key_valid high 10 cycles with opcode 6'h05 → exactly one accept. Then pulse 6'h05 again → dropped with no pulse. Then 6'h3F, then 6'h05 → accepted, bet_count = 2.
3. Bet with color 3'b000 → reject_pulse, bet_count unchanged. Spin (6'h3E) with bet_count = 0 → reject_pulse, spin_req stays 0.
4. 12 bets with alternating opcodes → full = 1, bet_count = 12, slot11 holds the last bet. 13th bet → reject_pulse, bet_count = 12. Spin → spin_req pulse, locked = 1.
5. While LOCKED, issue key events → no pulses, slots unchanged. Pulse spin_done together with a key event → one CLEAR cycle, then all slots = 0, bet_count = 0, locked = 0, state OPEN.
6. Assert reset low mid-round with 3 bets stored, asynchronously between clock edges → outputs clear before the next edge. After release, a new bet lands in slot0.

Source files
------------

// File: rtl/bet_ledger_if.sv
// bet_ledger_if: bundles the keyboard/bet event inputs, the spin handshake
// and the ledger outputs of bet_ledger.
//   master : drives key_valid, bet_opcode, color, spin_done; observes ledger
//   slave  : the ledger itself (bet_ledger)
// Signals:
//   key_valid    keyboard byte-received level/strobe
//   bet_opcode   decoded opcode (6'h3F no key, 6'h3E spin)
//   color        chip colour, 3'b000 = no chip present
//   spin_done    one-cycle pulse, spin result consumed
//   bets_flat    packed slots, slot i at [i*BET_W +: BET_W]
//   bet_count    filled slot count
//   full, locked, spin_req, accept_pulse, reject_pulse  status/pulses
interface bet_ledger_if #(
    parameter int NUM_BETS = 12,
    parameter int BET_W    = 8,
    parameter int CNT_W    = 4
);
    logic                      key_valid;
    logic [5:0]                bet_opcode;
    logic [2:0]                color;
    logic                      spin_done;
    logic [NUM_BETS*BET_W-1:0] bets_flat;
    logic [CNT_W-1:0]          bet_count;
    logic                      full;
    logic                      locked;
    logic                      spin_req;
    logic                      accept_pulse;
    logic                      reject_pulse;

    modport master (
        output key_valid, bet_opcode, color, spin_done,
        input  bets_flat, bet_count, full, locked,
               spin_req, accept_pulse, reject_pulse
    );

    modport slave (
        input  key_valid, bet_opcode, color, spin_done,
        output bets_flat, bet_count, full, locked,
               spin_req, accept_pulse, reject_pulse
    );
endinterface

// File: rtl/bet_ledger.sv
// bet_ledger: collects up to NUM_BETS colour-tagged bets into numbered slots,
// filters repeated / colourless / invalid key events, raises a spin request
// and holds the ledger locked until the spin completes, then clears it.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    bet_ledger_if.slave (key events in, ledger state and pulses out)
module bet_ledger #(
    parameter int NUM_BETS = 12,
    parameter int BET_W    = 8,
    parameter int CNT_W    = 4
) (
    input  logic        clock,
    input  logic        reset,
    bet_ledger_if.slave bus
);
    localparam logic [5:0] OP_NONE = 6'h3F;
    localparam logic [5:0] OP_SPIN = 6'h3E;

    typedef enum logic [1:0] {
        ST_OPEN,
        ST_LOCKED,
        ST_CLEAR
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_BETS*BET_W-1:0] bets_q, bets_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [5:0]                last_op_q, last_op_d;
    logic                      kv_q;
    logic                      spin_q, spin_d;
    logic                      acc_q, acc_d;
    logic                      rej_q, rej_d;
    logic                      key_event;
    logic                      is_full;

    // Rising edge of key_valid: a held key produces a single event.
    assign key_event = bus.key_valid & ~kv_q;
    assign is_full   = (count_q == CNT_W'(NUM_BETS));

    always_comb begin
        state_d   = state_q;
        bets_d    = bets_q;
        count_d   = count_q;
        last_op_d = last_op_q;
        spin_d    = 1'b0;
        acc_d     = 1'b0;
        rej_d     = 1'b0;
        unique case (state_q)
            ST_OPEN: begin
                if (key_event) begin
                    if (bus.bet_opcode == OP_NONE) begin
                        // Key release: re-arms the repeat filter, no pulse.
                        last_op_d = OP_NONE;
                    end else if (bus.bet_opcode != last_op_q) begin
                        last_op_d = bus.bet_opcode;
                        if (bus.bet_opcode == OP_SPIN) begin
                            if (count_q != '0) begin
                                spin_d  = 1'b1;
                                state_d = ST_LOCKED;
                            end else begin
                                rej_d = 1'b1;
                            end
                        end else if (bus.color == 3'b000 || is_full) begin
                            rej_d = 1'b1;
                        end else begin
                            bets_d[int'(count_q)*BET_W +: BET_W] =
                                {bus.color[1:0], bus.bet_opcode};
                            count_d = count_q + CNT_W'(1);
                            acc_d   = 1'b1;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                // Key events are ignored here; spin_done wins over any key.
                if (bus.spin_done) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                bets_d    = '0;
                count_d   = '0;
                last_op_d = OP_NONE;
                state_d   = ST_OPEN;
            end
            default: state_d = ST_OPEN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_OPEN;
            bets_q    <= '0;
            count_q   <= '0;
            last_op_q <= OP_NONE;
            kv_q      <= 1'b0;
            spin_q    <= 1'b0;
            acc_q     <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bets_q    <= bets_d;
            count_q   <= count_d;
            last_op_q <= last_op_d;
            kv_q      <= bus.key_valid;
            spin_q    <= spin_d;
            acc_q     <= acc_d;
            rej_q     <= rej_d;
        end
    end

    assign bus.bets_flat    = bets_q;
    assign bus.bet_count    = count_q;
    assign bus.full         = is_full;
    assign bus.locked       = (state_q == ST_LOCKED);
    assign bus.spin_req     = spin_q;
    assign bus.accept_pulse = acc_q;
    assign bus.reject_pulse = rej_q;
endmodule

// File: tb/tb_bet_ledger.sv
// tb_bet_ledger: directed-vector bench for bet_ledger with hand-computed
// expected slot contents, counts and pulse timing.
module tb_bet_ledger;
    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    bet_ledger_if #(.NUM_BETS(12), .BET_W(8), .CNT_W(4)) bif ();

    bet_ledger #(.NUM_BETS(12), .BET_W(8), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single-cycle key event; returns in cycle N+1 where pulses are visible.
    task automatic press(input logic [5:0] op, input logic [2:0] col);
        bif.bet_opcode = op;
        bif.color      = col;
        bif.key_valid  = 1'b1;
        tick();
        bif.key_valid  = 1'b0;
    endtask

    function automatic logic [7:0] slot(input int i);
        logic [95:0] f;
        f = bif.bets_flat;
        return f[i*8 +: 8];
    endfunction

    task automatic check_pulses(input string tag, input logic a,
                                input logic r, input logic s);
        check({tag, "_acc"},  128'(bif.accept_pulse), 128'(a));
        check({tag, "_rej"},  128'(bif.reject_pulse), 128'(r));
        check({tag, "_spin"}, 128'(bif.spin_req),     128'(s));
    endtask

    initial begin
        int acc_sum;
        int rej_sum;
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        bif.key_valid = 1'b0;
        bif.bet_opcode = 6'h3F;
        bif.color     = 3'b000;
        bif.spin_done = 1'b0;

        // 1. reset state
        tick(); tick();
        check("rst_bets",   128'(bif.bets_flat), 128'(0));
        check("rst_count",  128'(bif.bet_count), 128'(0));
        check("rst_full",   128'(bif.full),      128'(0));
        check("rst_locked", 128'(bif.locked),    128'(0));
        check_pulses("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();

        // spin with empty ledger is refused
        press(6'h3E, 3'b010);
        check_pulses("spin_empty", 1'b0, 1'b1, 1'b0);
        check("spin_empty_locked", 128'(bif.locked), 128'(0));
        tick();

        // first bet: {2'b10, 6'h05} = 8'h85
        press(6'h05, 3'b010);
        check_pulses("bet1", 1'b1, 1'b0, 1'b0);
        check("bet1_count", 128'(bif.bet_count), 128'(1));
        check("bet1_slot0", 128'(slot(0)), 128'(8'h85));
        tick();
        check("bet1_acc_off", 128'(bif.accept_pulse), 128'(0));

        // 2. re-arm with 3F, then hold 05 for 10 cycles -> one accept
        press(6'h3F, 3'b010);
        check_pulses("none_key", 1'b0, 1'b0, 1'b0);
        tick();
        acc_sum = 0;
        rej_sum = 0;
        bif.bet_opcode = 6'h05;
        bif.color      = 3'b010;
        bif.key_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            acc_sum += int'(bif.accept_pulse);
            rej_sum += int'(bif.reject_pulse);
        end
        bif.key_valid = 1'b0;
        tick();
        acc_sum += int'(bif.accept_pulse);
        check("hold_accepts", 128'(acc_sum), 128'(1));
        check("hold_rejects", 128'(rej_sum), 128'(0));
        check("hold_count",   128'(bif.bet_count), 128'(2));

        press(6'h05, 3'b010);
        check_pulses("repeat", 1'b0, 1'b0, 1'b0);
        check("repeat_count", 128'(bif.bet_count), 128'(2));
        tick();
        press(6'h3F, 3'b010);
        tick();
        press(6'h05, 3'b010);
        check_pulses("rearm", 1'b1, 1'b0, 1'b0);
        check("rearm_count", 128'(bif.bet_count), 128'(3));
        check("rearm_low",   128'(bif.bets_flat[23:0]), 128'(24'h858585));
        tick();

        // 3. colourless bet refused
        press(6'h07, 3'b000);
        check_pulses("nocolor", 1'b0, 1'b1, 1'b0);
        check("nocolor_count", 128'(bif.bet_count), 128'(3));
        tick();

        // 4. fill slots 3..11 alternating 0x50 / 0x51 (colour 01)
        for (int i = 0; i < 9; i++) begin
            press(6'h10 + 6'(i % 2), 3'b001);
            check("fill_acc",   128'(bif.accept_pulse), 128'(1));
            check("fill_count", 128'(bif.bet_count), 128'(4 + i));
            check("fill_full",  128'(bif.full), 128'(i == 8 ? 1 : 0));
            tick();
        end
        check("full_bets", 128'(bif.bets_flat),
              128'(96'h50_51_50_51_50_51_50_51_50_85_85_85));
        check("full_slot11", 128'(slot(11)), 128'(8'h50));

        press(6'h11, 3'b001);
        check_pulses("bet13", 1'b0, 1'b1, 1'b0);
        check("bet13_count", 128'(bif.bet_count), 128'(12));
        tick();

        press(6'h3E, 3'b001);
        check_pulses("spin", 1'b0, 1'b0, 1'b1);
        check("spin_locked", 128'(bif.locked), 128'(1));
        tick();
        check("spin_pulse_off", 128'(bif.spin_req), 128'(0));
        check("spin_locked2",   128'(bif.locked), 128'(1));

        // 5. key events ignored while locked
        press(6'h20, 3'b011);
        check_pulses("lock_key", 1'b0, 1'b0, 1'b0);
        check("lock_bets", 128'(bif.bets_flat),
              128'(96'h50_51_50_51_50_51_50_51_50_85_85_85));
        tick();
        press(6'h3E, 3'b011);
        check_pulses("lock_spin", 1'b0, 1'b0, 1'b0);
        tick();

        // spin_done together with a key event
        bif.spin_done  = 1'b1;
        bif.bet_opcode = 6'h21;
        bif.color      = 3'b011;
        bif.key_valid  = 1'b1;
        tick();
        bif.spin_done  = 1'b0;
        bif.key_valid  = 1'b0;
        check("clear_locked", 128'(bif.locked), 128'(0));
        check_pulses("clear", 1'b0, 1'b0, 1'b0);
        tick();
        check("open_bets",   128'(bif.bets_flat), 128'(0));
        check("open_count",  128'(bif.bet_count), 128'(0));
        check("open_full",   128'(bif.full), 128'(0));
        check("open_locked", 128'(bif.locked), 128'(0));

        press(6'h21, 3'b011);
        check_pulses("newround", 1'b1, 1'b0, 1'b0);
        check("newround_slot0", 128'(slot(0)), 128'(8'hE1));
        tick();

        // 6. asynchronous reset mid-round with 3 bets stored
        press(6'h22, 3'b010);
        tick();
        press(6'h23, 3'b010);
        tick();
        check("pre_rst_count", 128'(bif.bet_count), 128'(3));
        check("pre_rst_low",   128'(bif.bets_flat[23:0]), 128'(24'hA3A2E1));
        #3;
        reset = 1'b0;
        #1;
        check("arst_count", 128'(bif.bet_count), 128'(0));
        check("arst_bets",  128'(bif.bets_flat), 128'(0));
        check("arst_full",  128'(bif.full), 128'(0));
        tick();
        reset = 1'b1;
        tick();
        press(6'h05, 3'b010);
        check_pulses("post_rst", 1'b1, 1'b0, 1'b0);
        check("post_rst_slot0", 128'(slot(0)), 128'(8'h85));
        check("post_rst_count", 128'(bif.bet_count), 128'(1));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
